// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x WORDSIZE integer register file, x0 hardwired to zero, write-to-read bypass
module register_file #(
  parameter int WORDSIZE = 64,
  parameter int REGCOUNT = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reg_write,
  input  logic [$clog2(REGCOUNT)-1:0] rd,
  input  logic [WORDSIZE-1:0]         data_in,
  input  logic [$clog2(REGCOUNT)-1:0] rs1,
  input  logic [$clog2(REGCOUNT)-1:0] rs2,
  output logic [WORDSIZE-1:0]         data_out1,
  output logic [WORDSIZE-1:0]         data_out2
);

  localparam int IDXW = $clog2(REGCOUNT);

  logic [WORDSIZE-1:0] regs_q [REGCOUNT];
  logic [WORDSIZE-1:0] regs_d [REGCOUNT];
  logic                wr_en;

  // Entry 0 only ever holds zero; reads of index 0 never reach it anyway.
  assign wr_en = reg_write && (rd != '0);

  always_comb begin
    for (int i = 0; i < REGCOUNT; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[rd] = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REGCOUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REGCOUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  logic bypass1;
  logic bypass2;

  // Bypass is disabled during reset: the pending write will be dropped.
  assign bypass1 = reset && wr_en && (rd == rs1);
  assign bypass2 = reset && wr_en && (rd == rs2);

  assign data_out1 = (rs1 == IDXW'(0)) ? '0 : (bypass1 ? data_in : regs_q[rs1]);
  assign data_out2 = (rs2 == IDXW'(0)) ? '0 : (bypass2 ? data_in : regs_q[rs2]);

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized scoreboard bench for register_file against an array model
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  rd;
  logic [63:0] data_in;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] data_out1;
  logic [63:0] data_out2;

  register_file #(.WORDSIZE(64), .REGCOUNT(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .rd        (rd),
    .data_in   (data_in),
    .rs1       (rs1),
    .rs2       (rs2),
    .data_out1 (data_out1),
    .data_out2 (data_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] o1;
    logic [63:0] o2;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model [32];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [63:0] ref_read(input logic r, input logic we, input logic [4:0] d,
                                           input logic [63:0] din, input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (r && we && d == a) return din;
    return model[a];
  endfunction

  task automatic cyc(input logic r, input logic we, input logic [4:0] d, input logic [63:0] din,
                     input logic [4:0] a, input logic [4:0] b, input string tag);
    exp_t e;
    reset = r; reg_write = we; rd = d; data_in = din; rs1 = a; rs2 = b;
    e.o1 = ref_read(r, we, d, din, a);
    e.o2 = ref_read(r, we, d, din, b);
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end else if (we && d != 5'd0) begin
      model[d] = din;
    end
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (data_out1 !== e.o1) begin
          n_err++;
          $display("FAIL %s out1: got %h expected %h", e.tag, data_out1, e.o1);
        end
        n_cmp++;
        if (data_out2 !== e.o2) begin
          n_err++;
          $display("FAIL %s out2: got %h expected %h", e.tag, data_out2, e.o2);
        end
      end
    end
  end

  initial begin : stim
    logic        r, we;
    logic [4:0]  d, a, b;
    logic [63:0] din;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    reset = 1'b0; reg_write = 1'b0; rd = 5'd0; data_in = 64'd0; rs1 = 5'd0; rs2 = 5'd0;
    @(posedge clk); #1;

    cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, "reset_x0");
    cyc(1'b0, 1'b1, 5'd5, 64'h77, 5'd5, 5'd31, "reset_hold");
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd31, "reset_read");
    cyc(1'b1, 1'b1, 5'd7, 64'h14a7_e226_fc32_92a1, 5'd1, 5'd2, "wr7");
    cyc(1'b1, 1'b0, 5'd7, 64'd0, 5'd7, 5'd8, "rd7");
    cyc(1'b1, 1'b1, 5'd0, 64'hffff_ffff_ffff_ffff, 5'd0, 5'd0, "x0_wr");
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, "x0_rd");
    cyc(1'b1, 1'b1, 5'd3, 64'h1, 5'd0, 5'd0, "wr3");
    cyc(1'b1, 1'b1, 5'd3, 64'h2, 5'd3, 5'd3, "bypass3");
    cyc(1'b1, 1'b0, 5'd3, 64'd0, 5'd3, 5'd3, "after_bypass3");
    cyc(1'b1, 1'b0, 5'd9, 64'hffff_ffff_ffff_ffff, 5'd9, 5'd9, "wr_dis");
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 5'd9, 5'd7, "wr_dis_rd");
    cyc(1'b1, 1'b1, 5'd12, 64'hdead_beef, 5'd0, 5'd0, "wr12");
    cyc(1'b0, 1'b1, 5'd12, 64'h5, 5'd12, 5'd12, "rst_prio");
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 5'd12, 5'd7, "rst_prio_after");
    cyc(1'b1, 1'b1, 5'd31, 64'hcafe_f00d_1234_5678, 5'd31, 5'd30, "wr31_bypass");
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 5'd31, 5'd31, "rd31");

    for (int k = 0; k < 600; k++) begin
      r   = ($urandom_range(0, 24) != 0);
      we  = 1'($urandom_range(0, 1));
      d   = 5'($urandom_range(0, 31));
      din = {$urandom, $urandom};
      a   = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      b   = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      cyc(r, we, d, din, a, b, "rand");
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
